// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - WIDTH-bit adder built on one shared external 1-bit full adder, LSB first
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             carry_r;
    logic [CW-1:0]    cnt;

    // busy is high exactly in RUN, so it gates the adder operands to 0 elsewhere
    assign fa_a     = busy & a_sr[0];
    assign fa_b     = busy & b_sr[0];
    assign fa_cin   = busy & carry_r;
    assign res_next = WIDTH'({fa_sum, res_sr} >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            carry_r   <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry_r <= c_in;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    res_sr  <= res_next;
                    carry_r <= fa_cout;
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum       <= res_next;
                        carry_out <= fa_cout;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - randomized self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry_out;
    logic       fa_a;
    logic       fa_b;
    logic       fa_cin;
    logic       fa_sum;
    logic       fa_cout;

    int total = 0;
    int bad   = 0;

    logic [7:0] held_sum = 8'h00;
    logic       held_co  = 1'b0;

    always #5 clk = ~clk;

    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .sum(sum), .carry_out(carry_out),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_sum(fa_sum), .fa_cout(fa_cout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // poke >= 0 re-asserts start with a=0 at that RUN cycle, which must be ignored
    task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic oc, input int poke);
        logic [8:0] exp;
        exp = 9'(oa) + 9'(ob) + 9'(oc);
        @(negedge clk);
        a = oa; b = ob; c_in = oc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("run_busy", busy, 1'b1);
            check("run_done", done, 1'b0);
            check("run_sum_hold", sum, held_sum);
            check("run_co_hold", carry_out, held_co);
            if (i == 0) begin
                check("fa_a_bit0", fa_a, oa[0]);
                check("fa_b_bit0", fa_b, ob[0]);
                check("fa_cin_first", fa_cin, oc);
            end
            if (i == poke) begin
                start = 1'b1;
                a = 8'h00;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("sum", sum, exp[7:0]);
        check("carry_out", carry_out, exp[8]);
        check("done_fa_zero", {fa_a, fa_b, fa_cin}, 3'b000);
        held_sum = exp[7:0];
        held_co  = exp[8];
        @(negedge clk);
        check("idle_done", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_fa_zero", {fa_a, fa_b, fa_cin}, 3'b000);
        @(negedge clk);
        check("no_requeue", busy, 1'b0);
    endtask

    initial begin
        int cyc;
        int first_done;
        int ndone;
        logic [7:0] ra;
        logic [7:0] rb;

        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; c_in = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, 8'h00);
        check("rst_co", carry_out, 1'b0);
        check("rst_fa", {fa_a, fa_b, fa_cin}, 3'b000);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(8'h00, 8'h00, 1'b0, -1);
        run_op(8'hFF, 8'h01, 1'b0, -1);
        run_op(8'hFF, 8'hFF, 1'b1, -1);
        run_op(8'hA5, 8'h5A, 1'b0, 3);

        // abort mid-operation
        @(negedge clk);
        a = 8'h12; b = 8'h34; c_in = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_sum", sum, 8'h00);
        check("abort_co", carry_out, 1'b0);
        check("abort_fa", {fa_a, fa_b, fa_cin}, 3'b000);
        held_sum = 8'h00;
        held_co  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_op(8'h3C, 8'h0F, 1'b0, -1);

        // back-to-back with start held high
        @(negedge clk);
        a = 8'h01; b = 8'h01; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 a = 8'h80; b = 8'h80;
        first_done = -1;
        ndone = 0;
        cyc = 0;
        while (ndone < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    first_done = cyc;
                    check("b2b_sum1", sum, 8'h02);
                    check("b2b_co1", carry_out, 1'b0);
                end else begin
                    start = 1'b0;
                    check("b2b_period", cyc - first_done, 10);
                    check("b2b_sum2", sum, 8'h00);
                    check("b2b_co2", carry_out, 1'b1);
                end
            end
        end
        start = 1'b0;
        check("b2b_done_count", ndone, 2);
        held_sum = sum;
        held_co  = carry_out;
        repeat (3) @(negedge clk);
        check("b2b_settled", busy, 1'b0);
        held_sum = 8'h00;
        held_co  = 1'b1;

        for (int k = 0; k < 20; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 9)) - 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
